mealey_accum_mc: RTL and testbench

Parametrised multi-channel Mealy accumulator, the next generation of the single-channel 9-bit signed Mealy top entity. It keeps one signed running sum per channel, updates the addressed channel on each valid input sample, and returns the updated sum one cycle later. Overflow is handled by a selectable saturate or wrap mode and reported per sample. The block sits between a time-multiplexed sample source and downstream consumers in the Mealy tutorial design.

---
 rtl/mealey_accum_mc.sv | 92 +++++++++
 tb/tb_mealey_accum_mc.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mealey_accum_mc.sv
// Multi-channel signed Mealy accumulator: one running sum per channel, updated
// on each valid sample, with the registered result one cycle later.
module mealey_accum_mc #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 4,
  parameter int SATURATE = 1,
  parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                    system1000,
  input  logic                    system1000_rst,
  input  logic                    input_valid,
  input  logic [CW-1:0]           input_chan,
  input  logic                    input_clear,
  input  logic signed [WIDTH-1:0] input_0,
  output logic                    output_valid,
  output logic [CW-1:0]           output_chan,
  output logic signed [WIDTH-1:0] output_0,
  output logic                    output_ovf
);

  localparam logic signed [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [WIDTH-1:0] acc_q [CHANNELS];
  logic signed [WIDTH-1:0] acc_sel;
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] result;
  logic                    sum_ovf;
  logic                    result_ovf;
  logic                    chan_ok;
  logic                    accept;

  // Out-of-range indices only exist when CHANNELS is not a power of two.
  assign chan_ok = ({1'b0, input_chan} < (CW+1)'(CHANNELS));
  assign accept  = input_valid && chan_ok;

  always_comb begin
    acc_sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (input_chan == CW'(i)) acc_sel = acc_q[i];
    end
  end

  assign sum     = {acc_sel[WIDTH-1], acc_sel} + {input_0[WIDTH-1], input_0};
  assign sum_ovf = sum[WIDTH] ^ sum[WIDTH-1];

  always_comb begin
    result     = sum[WIDTH-1:0];
    result_ovf = sum_ovf;
    if (input_clear) begin
      result     = input_0;
      result_ovf = 1'b0;
    end else if ((SATURATE != 0) && sum_ovf) begin
      // The extra top bit carries the true sign of the unclamped sum.
      result = sum[WIDTH] ? MIN_VAL : MAX_VAL;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic signed [WIDTH-1:0] acc_reg;
      always_ff @(posedge system1000) begin
        if (system1000_rst) begin
          acc_reg <= '0;
        end else if (accept && (input_chan == CW'(gi))) begin
          acc_reg <= result;
        end
      end
      assign acc_q[gi] = acc_reg;
    end
  endgenerate

  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      output_valid <= 1'b0;
      output_chan  <= '0;
      output_0     <= '0;
      output_ovf   <= 1'b0;
    end else begin
      output_valid <= accept;
      if (accept) begin
        output_chan <= input_chan;
        output_0    <= result;
        output_ovf  <= result_ovf;
      end else begin
        output_ovf  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mealey_accum_mc.sv
// Bench for mealey_accum_mc: three instances (saturate/4ch, wrap/4ch, saturate/3ch)
// checked every cycle against an integer-arithmetic reference model.
module tb_mealey_accum_mc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              v   [3];
  logic [1:0]        ch  [3];
  logic              clr [3];
  logic signed [8:0] din [3];
  logic              ov  [3];
  logic [1:0]        oc  [3];
  logic signed [8:0] o0  [3];
  logic              of  [3];

  mealey_accum_mc #(.WIDTH(9), .CHANNELS(4), .SATURATE(1)) u_sat (
    .system1000(clk), .system1000_rst(rst),
    .input_valid(v[0]), .input_chan(ch[0]), .input_clear(clr[0]), .input_0(din[0]),
    .output_valid(ov[0]), .output_chan(oc[0]), .output_0(o0[0]), .output_ovf(of[0]));

  mealey_accum_mc #(.WIDTH(9), .CHANNELS(4), .SATURATE(0)) u_wrap (
    .system1000(clk), .system1000_rst(rst),
    .input_valid(v[1]), .input_chan(ch[1]), .input_clear(clr[1]), .input_0(din[1]),
    .output_valid(ov[1]), .output_chan(oc[1]), .output_0(o0[1]), .output_ovf(of[1]));

  mealey_accum_mc #(.WIDTH(9), .CHANNELS(3), .SATURATE(1)) u_ch3 (
    .system1000(clk), .system1000_rst(rst),
    .input_valid(v[2]), .input_chan(ch[2]), .input_clear(clr[2]), .input_0(din[2]),
    .output_valid(ov[2]), .output_chan(oc[2]), .output_0(o0[2]), .output_ovf(of[2]));

  int n_checks = 0;
  int n_errors = 0;

  const int sat_p [3] = '{1, 0, 1};
  const int nch_p [3] = '{4, 4, 3};
  int acc_m [3][4];
  int e_v [3];
  int e_c [3];
  int e_o [3];
  int e_f [3];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    for (int d = 0; d < 3; d++) begin
      v[d] = 1'b0; clr[d] = 1'b0; ch[d] = 2'd0; din[d] = '0;
    end
  endtask

  task automatic drive(input int d, input int c, input int x, input bit c_lr);
    v[d] = 1'b1; ch[d] = c[1:0]; din[d] = x[8:0]; clr[d] = c_lr;
  endtask

  // Predict, clock once, then compare all three instances one edge later.
  task automatic step();
    int c, x, s, ovf, r;
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        for (int k = 0; k < 4; k++) acc_m[d][k] = 0;
        e_v[d] = 0; e_c[d] = 0; e_o[d] = 0; e_f[d] = 0;
      end else if (v[d] && (int'(ch[d]) < nch_p[d])) begin
        c   = int'(ch[d]);
        x   = int'(din[d]);
        s   = acc_m[d][c] + x;
        ovf = (s > 255 || s < -256) ? 1 : 0;
        if (clr[d]) begin
          r = x; ovf = 0;
        end else if (ovf != 0 && sat_p[d] != 0) begin
          r = (s > 0) ? 255 : -256;
        end else begin
          r = ((s + 768) % 512) - 256;
        end
        acc_m[d][c] = r;
        e_v[d] = 1; e_c[d] = c; e_o[d] = r; e_f[d] = ovf;
      end else begin
        e_v[d] = 0; e_f[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d valid", d), int'(ov[d]), e_v[d]);
      check($sformatf("d%0d chan", d),  int'(oc[d]), e_c[d]);
      check($sformatf("d%0d out", d),   int'(o0[d]), e_o[d]);
      check($sformatf("d%0d ovf", d),   int'(of[d]), e_f[d]);
    end
    $display("t=%0t rst=%0d | d0 v=%0d c=%0d o=%0d f=%0d | d1 v=%0d c=%0d o=%0d f=%0d | d2 v=%0d c=%0d o=%0d f=%0d",
             $time, rst, ov[0], oc[0], o0[0], of[0], ov[1], oc[1], o0[1], of[1],
             ov[2], oc[2], o0[2], of[2]);
  endtask

  initial begin
    idle_all();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Back-to-back interleaved accumulation
    drive(0, 0, 100, 0); step(); idle_all();
    check("dir ch0 +100", int'(o0[0]), 100);
    drive(0, 1, -5, 0);  step(); idle_all();
    drive(0, 0, 20, 0);  step(); idle_all();
    check("dir ch0 120", int'(o0[0]), 120);
    drive(0, 1, -7, 0);  step(); idle_all();
    check("dir ch1 -12", int'(o0[0]), -12);

    // Positive and negative saturation
    drive(0, 2, 200, 0);  step(); idle_all();
    drive(0, 2, 100, 0);  step(); idle_all();
    check("dir sat max", int'(o0[0]), 255);
    check("dir sat ovf", int'(of[0]), 1);
    drive(0, 2, -256, 0); step(); idle_all();
    check("dir sat back", int'(o0[0]), -1);
    drive(0, 3, -200, 0); step(); idle_all();
    drive(0, 3, -100, 0); step(); idle_all();
    check("dir sat min", int'(o0[0]), -256);

    // Wrap mode
    drive(1, 0, 200, 0); step(); idle_all();
    drive(1, 0, 100, 0); step(); idle_all();
    check("dir wrap val", int'(o0[1]), -212);
    check("dir wrap ovf", int'(of[1]), 1);

    // Clear restarts a channel
    drive(0, 1, 62, 0); step(); idle_all();
    check("dir ch1 50", int'(o0[0]), 50);
    drive(0, 1, -7, 1); step(); idle_all();
    check("dir clear", int'(o0[0]), -7);
    drive(0, 1, 3, 0);  step(); idle_all();
    check("dir after clear", int'(o0[0]), -4);

    // Idle keeps state; clear without valid is ignored
    clr[0] = 1'b1; step(); idle_all();
    step(); step();
    drive(0, 0, 1, 0); step(); idle_all();
    check("dir idle resume", int'(o0[0]), 121);

    // Reset wins over a simultaneous sample
    drive(0, 0, 50, 0); rst = 1'b1; step(); rst = 1'b0; idle_all();
    drive(0, 0, 1, 0);  step(); idle_all();
    check("dir post reset", int'(o0[0]), 1);

    // Invalid channel on the 3-channel instance
    drive(2, 3, 77, 0); step(); idle_all();
    check("dir bad chan", int'(ov[2]), 0);
    drive(2, 0, 5, 0);  step(); idle_all();
    check("dir ch3 untouched", int'(o0[2]), 5);

    // Randomised traffic on all instances
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(99) == 0);
      for (int d = 0; d < 3; d++) begin
        v[d]   = ($urandom_range(3) != 0);
        ch[d]  = 2'($urandom_range(3));
        clr[d] = ($urandom_range(7) == 0);
        case ($urandom_range(3))
          0:       din[d] = 9'sd255;
          1:       din[d] = -9'sd256;
          default: din[d] = 9'($urandom);
        endcase
      end
      step();
    end
    rst = 1'b0;
    idle_all();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
